// File: rtl/pkg_uart.sv
// Shared types and constants for the UART receive path: parity modes,
// receiver FSM states and the per-frame status bit layout.
package pkg_uart;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } rx_state_t;

  localparam int ST_PARITY = 0;
  localparam int ST_FRAME  = 1;
  localparam int ST_BREAK  = 2;
  localparam int STATUS_W  = 3;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: a beat transfers when tvalid && tready.
interface axis_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// First-word-fallthrough synchronous FIFO with full/empty flags.
// A push while full is dropped, judged on the occupancy before any same-cycle pop.
module axis_sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             push_ok,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign drop     = push && full;
  assign pop_ok   = pop && !empty;
  // Head word is forced to zero while empty so the outputs read 0 out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_uart_rx_os.sv
// Oversampling UART receiver with majority-vote bit sampling, parity/frame/break
// status and an output FIFO presented as an AXI-Stream master.
module axis_uart_rx_os
  import pkg_uart::*;
#(
  parameter int      AXI_DATA_WIDTH = 32,
  parameter int      CLOCK          = 100_000_000,
  parameter int      BAUD_RATE      = 115200,
  parameter int      OVERSAMPLE     = 16,
  parameter int      DATA_BITS      = 8,
  parameter parity_t PARITY         = PARITY_NONE,
  parameter int      STOP_BITS      = 1,
  parameter int      FIFO_DEPTH     = 16
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       uart_rx,
  axis_if.master     m_axis,
  output logic [2:0] rx_status,
  output logic       rx_done,
  output logic       rx_overflow
);
  localparam int DIV = CLOCK / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = $clog2(DIV + 1);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int FW  = STATUS_W + AXI_DATA_WIDTH;

  logic sync1, sync2, rx_prev, fall;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= uart_rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  assign fall = rx_prev & ~sync2;

  rx_state_t          state_q, state_d;
  logic [DW-1:0]      div_cnt;
  logic [SW-1:0]      smp_cnt;
  logic [3:0]         bit_cnt;
  logic               s0, s1;
  logic [DATA_BITS-1:0] shift_q;
  logic               all_zero_q, par_err_q, ferr_q, stop0_zero_q;
  logic               push_q;
  logic [FW-1:0]      push_word_q;

  logic tick, mid_tick, end_tick, maj;
  logic last_data, last_stop, brk_now, ferr_now;
  logic [STATUS_W-1:0]       frame_status;
  logic [AXI_DATA_WIDTH-1:0] frame_data;

  assign tick      = (state_q != S_IDLE) && (div_cnt == DW'(DIV - 1));
  assign mid_tick  = tick && (smp_cnt == SW'(OVERSAMPLE / 2 + 1));
  assign end_tick  = tick && (smp_cnt == SW'(OVERSAMPLE - 1));
  assign maj       = majority3(s0, s1, sync2);
  assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
  // Break needs every data/parity bit low and the first stop bit low.
  assign brk_now   = all_zero_q && ((bit_cnt == 4'd0) ? !maj : stop0_zero_q);
  assign ferr_now  = ferr_q | !maj;

  always_comb begin
    frame_status = '0;
    frame_data   = AXI_DATA_WIDTH'(shift_q);
    if (brk_now) begin
      frame_status[ST_BREAK] = 1'b1;
      frame_status[ST_FRAME] = 1'b1;
      frame_data             = '0;
    end else begin
      frame_status[ST_PARITY] = par_err_q;
      frame_status[ST_FRAME]  = ferr_now;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (fall) state_d = S_START;
      S_START: begin
        if (mid_tick && maj) state_d = S_IDLE;
        else if (end_tick)   state_d = S_DATA;
      end
      S_DATA:       if (end_tick && last_data)
                      state_d = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
      S_PARITY:     if (end_tick) state_d = S_STOP;
      S_STOP:       if (mid_tick && last_stop)
                      state_d = brk_now ? S_BREAK_WAIT : S_IDLE;
      S_BREAK_WAIT: if (sync2) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      div_cnt      <= '0;
      smp_cnt      <= '0;
      bit_cnt      <= '0;
      s0           <= 1'b1;
      s1           <= 1'b1;
      shift_q      <= '0;
      all_zero_q   <= 1'b0;
      par_err_q    <= 1'b0;
      ferr_q       <= 1'b0;
      stop0_zero_q <= 1'b0;
      push_q       <= 1'b0;
      push_word_q  <= '0;
    end else begin
      push_q <= 1'b0;
      // Bit timing restarts from zero at every start detection.
      if (state_q == S_IDLE) begin
        div_cnt <= '0;
        smp_cnt <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        smp_cnt <= (smp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : smp_cnt + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (tick && smp_cnt == SW'(OVERSAMPLE / 2 - 1)) s0 <= sync2;
      if (tick && smp_cnt == SW'(OVERSAMPLE / 2))     s1 <= sync2;
      if (state_d != state_q) bit_cnt <= '0;
      else if (end_tick)      bit_cnt <= bit_cnt + 1'b1;

      case (state_q)
        S_IDLE: if (fall) begin
          all_zero_q   <= 1'b1;
          par_err_q    <= 1'b0;
          ferr_q       <= 1'b0;
          stop0_zero_q <= 1'b0;
        end
        S_DATA: if (mid_tick) begin
          shift_q <= {maj, shift_q[DATA_BITS-1:1]};
          if (maj) all_zero_q <= 1'b0;
        end
        S_PARITY: if (mid_tick) begin
          par_err_q <= (^shift_q) ^ maj ^ (PARITY == PARITY_ODD);
          if (maj) all_zero_q <= 1'b0;
        end
        S_STOP: if (mid_tick) begin
          if (!maj) ferr_q <= 1'b1;
          if (bit_cnt == 4'd0) stop0_zero_q <= !maj;
          if (last_stop) begin
            push_q      <= 1'b1;
            push_word_q <= {frame_status, frame_data};
          end
        end
        default: ;
      endcase
    end
  end

  // Output handshake: a word is offered while tvalid is high and holds
  // tdata/rx_status stable until the cycle where tvalid && tready retires it.
  logic [FW-1:0] head_word;
  logic          fifo_full, fifo_empty;

  axis_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (push_q),
    .push_data (push_word_q),
    .pop       (m_axis.tvalid && m_axis.tready),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_ok   (rx_done),
    .drop      (rx_overflow)
  );

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = head_word[AXI_DATA_WIDTH-1:0];
  assign rx_status     = head_word[FW-1:AXI_DATA_WIDTH];

endmodule

// File: tb/tb_axis_uart_rx_os.sv
// Bench for axis_uart_rx_os: three instances (default 8N1, 7E1 fast, 8N1 fast
// with a 4-deep FIFO) driven with directed frames; monitors pop an expected queue.
module tb_axis_uart_rx_os;
  import pkg_uart::*;

  localparam int W       = 35;
  localparam int BIT_A   = 868;
  localparam int BIT_F   = 64;

  logic       clk = 1'b0;
  logic       rst_n_a, rst_n_b, rst_n_c;
  logic [2:0] rx_line;
  logic [2:0] st_a, st_b, st_c;
  logic       done_a_p, done_b_p, done_c_p, ovf_a_p, ovf_b_p, ovf_c_p;

  int checks = 0;
  int errors = 0;
  int done_a = 0, done_b = 0, done_c = 0;
  int ovf_a = 0, ovf_b = 0, ovf_c = 0;

  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic [W-1:0] exp_c[$];

  always #5 clk = ~clk;

  axis_if #(.DATA_WIDTH(32)) axis_a ();
  axis_if #(.DATA_WIDTH(32)) axis_b ();
  axis_if #(.DATA_WIDTH(32)) axis_c ();

  axis_uart_rx_os dut_a (
    .aclk (clk), .aresetn (rst_n_a), .uart_rx (rx_line[0]), .m_axis (axis_a),
    .rx_status (st_a), .rx_done (done_a_p), .rx_overflow (ovf_a_p)
  );

  axis_uart_rx_os #(
    .BAUD_RATE (1_562_500), .DATA_BITS (7), .PARITY (PARITY_EVEN)
  ) dut_b (
    .aclk (clk), .aresetn (rst_n_b), .uart_rx (rx_line[1]), .m_axis (axis_b),
    .rx_status (st_b), .rx_done (done_b_p), .rx_overflow (ovf_b_p)
  );

  axis_uart_rx_os #(
    .BAUD_RATE (1_562_500), .FIFO_DEPTH (4)
  ) dut_c (
    .aclk (clk), .aresetn (rst_n_c), .uart_rx (rx_line[2]), .m_axis (axis_c),
    .rx_status (st_c), .rx_done (done_c_p), .rx_overflow (ovf_c_p)
  );

  task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: one per instance, sampling on the falling edge.
  always @(negedge clk) begin
    if (done_a_p) done_a++;
    if (done_b_p) done_b++;
    if (done_c_p) done_c++;
    if (ovf_a_p)  ovf_a++;
    if (ovf_b_p)  ovf_b++;
    if (ovf_c_p)  ovf_c++;
  end

  always @(negedge clk) begin
    if (rst_n_a && axis_a.tvalid && axis_a.tready) begin
      if (exp_a.size() == 0) compare("a_unexpected_beat", {st_a, axis_a.tdata}, '1);
      else compare("a_beat", {st_a, axis_a.tdata}, exp_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n_b && axis_b.tvalid && axis_b.tready) begin
      if (exp_b.size() == 0) compare("b_unexpected_beat", {st_b, axis_b.tdata}, '1);
      else compare("b_beat", {st_b, axis_b.tdata}, exp_b.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n_c && axis_c.tvalid && axis_c.tready) begin
      if (exp_c.size() == 0) compare("c_unexpected_beat", {st_c, axis_c.tdata}, '1);
      else compare("c_beat", {st_c, axis_c.tdata}, exp_c.pop_front());
    end
  end

  task automatic hold(input int idx, input logic v, input int cycles);
    rx_line[idx] = v;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input int idx, input int bit_cyc, input logic [8:0] data,
                            input int nbits, input bit has_par, input logic par,
                            input logic stop);
    hold(idx, 1'b0, bit_cyc);
    for (int i = 0; i < nbits; i++) hold(idx, data[i], bit_cyc);
    if (has_par) hold(idx, par, bit_cyc);
    hold(idx, stop, bit_cyc);
    hold(idx, 1'b1, bit_cyc);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0;
    rx_line = 3'b111;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    rst_n_c = 1'b0;
    axis_a.tready = 1'b1;
    axis_b.tready = 1'b1;
    axis_c.tready = 1'b1;
    repeat (5) @(posedge clk);
    #2;

    compare("rst_tvalid", W'(axis_a.tvalid), '0);
    compare("rst_tdata", W'(axis_a.tdata), '0);
    compare("rst_status", W'(st_a), '0);
    compare("rst_done_ovf", W'({done_a_p, ovf_a_p}), '0);
    compare("rst_state", W'(dut_a.state_q), W'(S_IDLE));

    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    rst_n_c = 1'b1;
    repeat (4) @(posedge clk);
    #2;

    // 8N1 at default rate
    exp_a.push_back({3'b000, 32'h0000_00A5});
    send_frame(0, BIT_A, 9'h0A5, 8, 1'b0, 1'b0, 1'b1);
    compare("a5_done_count", W'(done_a), W'(1));

    // Short low glitch is rejected as a false start
    hold(0, 1'b0, 200);
    hold(0, 1'b1, 600);
    compare("glitch_state_idle", W'(dut_a.state_q), W'(S_IDLE));
    compare("glitch_no_push", W'(done_a), W'(1));
    exp_a.push_back({3'b000, 32'h0000_0055});
    send_frame(0, BIT_A, 9'h055, 8, 1'b0, 1'b0, 1'b1);
    compare("x55_done_count", W'(done_a), W'(2));

    // 7E1: 0x07 has three ones, so parity 0 is wrong and 1 is right
    exp_b.push_back({3'b001, 32'h0000_0007});
    send_frame(1, BIT_F, 9'h007, 7, 1'b1, 1'b0, 1'b1);
    exp_b.push_back({3'b000, 32'h0000_0007});
    send_frame(1, BIT_F, 9'h007, 7, 1'b1, 1'b1, 1'b1);
    compare("par_done_count", W'(done_b), W'(2));

    // Frame error then break on instance c
    exp_c.push_back({3'b010, 32'h0000_003C});
    send_frame(2, BIT_F, 9'h03C, 8, 1'b0, 1'b0, 1'b0);
    hold(2, 1'b1, BIT_F);
    exp_c.push_back({3'b110, 32'h0000_0000});
    hold(2, 1'b0, 12 * BIT_F);
    compare("break_wait_state", W'(dut_c.state_q), W'(S_BREAK_WAIT));
    compare("break_one_entry", W'(done_c), W'(2));
    hold(2, 1'b1, 2 * BIT_F);
    compare("break_exit_idle", W'(dut_c.state_q), W'(S_IDLE));

    // Fill the 4-deep FIFO with back-pressure and overflow on the fifth frame
    axis_c.tready = 1'b0;
    d0 = done_c;
    o0 = ovf_c;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_c.push_back({3'b000, 32'(v)});
      send_frame(2, BIT_F, 9'(v), 8, 1'b0, 1'b0, 1'b1);
    end
    compare("fifo_done_count", W'(done_c - d0), W'(4));
    compare("fifo_ovf_count", W'(ovf_c - o0), W'(1));
    compare("fifo_head_held", W'({axis_c.tvalid, st_c, axis_c.tdata}), W'({1'b1, 3'b000, 32'h1}));
    hold(2, 1'b1, 10);
    compare("fifo_head_stable", W'({axis_c.tvalid, st_c, axis_c.tdata}), W'({1'b1, 3'b000, 32'h1}));
    axis_c.tready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    compare("fifo_drained_tvalid", W'(axis_c.tvalid), '0);
    compare("fifo_drained_queue", W'(exp_c.size()), '0);

    // Reset mid-frame with two entries queued
    axis_c.tready = 1'b0;
    d0 = done_c;
    send_frame(2, BIT_F, 9'h011, 8, 1'b0, 1'b0, 1'b1);
    send_frame(2, BIT_F, 9'h022, 8, 1'b0, 1'b0, 1'b1);
    compare("rst_two_queued", W'(done_c - d0), W'(2));
    hold(2, 1'b0, BIT_F);
    hold(2, 1'b1, BIT_F);
    hold(2, 1'b1, BIT_F / 2);
    rst_n_c = 1'b0;
    #1;
    compare("midrst_tvalid", W'(axis_c.tvalid), '0);
    compare("midrst_word", W'({st_c, axis_c.tdata}), '0);
    repeat (5) @(posedge clk);
    #2;
    rst_n_c = 1'b1;
    axis_c.tready = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    compare("postrst_empty", W'(axis_c.tvalid), '0);
    d0 = done_c;
    exp_c.push_back({3'b000, 32'h0000_0081});
    send_frame(2, BIT_F, 9'h081, 8, 1'b0, 1'b0, 1'b1);
    compare("postrst_done", W'(done_c - d0), W'(1));

    repeat (50) @(posedge clk);
    #2;
    compare("end_queue_a", W'(exp_a.size()), '0);
    compare("end_queue_b", W'(exp_b.size()), '0);
    compare("end_queue_c", W'(exp_c.size()), '0);
    compare("end_ovf_ab", W'(ovf_a + ovf_b), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
